// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the sequencer (master) and memory (slave).
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with shared memory port, counters, halt/fault.
// 4 cycles per ALU op, 5 per load/store plus one per memory wait cycle; stalls while mem_ready is low.
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 dec_is_load,
  input  logic                 dec_is_store,
  input  logic                 dec_is_halt,
  input  logic                 dec_reg_we,
  multicycle_ctrl_if.master    mem,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic [2:0]           state,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // The counter only needs to hold MEM_TIMEOUT-1; the limit is hit on the wait cycle that would reach MEM_TIMEOUT.
  localparam int              WAIT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit              TO_EN    = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               fault_q, fault_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic               mem_req_c;
  logic               mem_we_c;
  logic               mem_addr_sel_c;
  logic               wait_lim;

  assign wait_lim = TO_EN && (wait_q == WAIT_LIM);

  always_comb begin
    state_d        = state_q;
    fault_d        = fault_q;
    wait_d         = '0;
    cycle_d        = cycle_q;
    instret_d      = instret_q;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    ir_we          = 1'b0;
    pc_we          = 1'b0;
    rf_we          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_lim) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        state_d = dec_is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = (dec_is_load || dec_is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = dec_is_store;
        if (mem.mem_ready) begin
          state_d = S_WB;
        end else if (wait_lim) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        rf_we     = dec_reg_we;
        pc_we     = 1'b1;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
    endcase

    if ((state_q != S_IDLE) && (state_q != S_HALT)) cycle_d = cycle_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fault_q   <= 1'b0;
      wait_q    <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign mem.mem_req      = mem_req_c;
  assign mem.mem_we       = mem_we_c;
  assign mem.mem_addr_sel = mem_addr_sel_c;
  assign state            = state_q;
  assign halted           = (state_q == S_HALT);
  assign fault            = fault_q;
  assign cycle_cnt        = cycle_q;
  assign instret_cnt      = instret_q;

endmodule
